// File: rtl/prio_encod_pkg.sv
// Shared types, constants and helpers for the pipelined priority encoder.
//   mode_e          : arbitration mode carried with each input transfer
//   GRANT_CNT_W     : width of the optional grant counter
//   onehot_of(idx)  : one-hot expansion, ONEHOT_MAX_W wide; callers slice to N
package prio_encod_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int GRANT_CNT_W  = 16;
  localparam int ONEHOT_MAX_W = 1024;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot_of(input int unsigned idx);
    logic [ONEHOT_MAX_W-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/prio_encod_pipe_find_hi.sv
// prio_find_hi: combinational highest-set-bit search.
//   vec   [N-1:0]  : candidate bits
//   idx   [IW-1:0] : index of the highest set bit (0 when none)
//   found          : any bit of vec set
module prio_find_hi #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Ascending scan: the last hit overwrites, so the highest index wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encod_pipe.sv
// prio_encod_pipe: registered priority encoder with valid/ready handshake,
// fixed (highest index wins) and round-robin arbitration.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : input handshake; req + mode sampled on transfer
//   out_valid/out_ready   : output handshake; one-entry result register
//   out_idx/out_onehot    : winning index and its one-hot form
//   out_any               : req was non-zero at the transfer
//   grant_cnt             : saturating count of non-zero transfers
//                           (only with PRIO_ENCOD_PIPE_GRANT_CNT_EN defined)
module prio_encod_pipe
  import prio_encod_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           req,
  input  logic                   mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IW-1:0]          out_idx,
  output logic [N-1:0]           out_onehot,
`ifdef PRIO_ENCOD_PIPE_GRANT_CNT_EN
  output logic [GRANT_CNT_W-1:0] grant_cnt,
`endif
  output logic                   out_any
);

  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic [N-1:0]  out_onehot_q, out_onehot_d;
  logic          out_any_q, out_any_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  logic          xfer;
  logic [N-1:0]  below_mask;
  logic [IW-1:0] hi_idx, msk_idx, win_idx;
  logic          hi_found, msk_found;
  logic [ONEHOT_MAX_W-1:0] oh_full;

  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  // Bits strictly below rr_ptr: searching them first gives the order
  // rr_ptr-1 .. 0, then the unmasked search wraps to N-1 .. rr_ptr.
  always_comb begin
    below_mask = '0;
    for (int i = 0; i < N; i++) below_mask[i] = (IW'(i) < rr_ptr_q);
  end

  prio_find_hi #(.N(N), .IW(IW)) u_find_all (
    .vec(req), .idx(hi_idx), .found(hi_found)
  );

  prio_find_hi #(.N(N), .IW(IW)) u_find_msk (
    .vec(req & below_mask), .idx(msk_idx), .found(msk_found)
  );

  assign win_idx = (mode_e'(mode) == MODE_RR && msk_found) ? msk_idx : hi_idx;
  assign oh_full = onehot_of(win_idx);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_onehot_d = out_onehot_q;
    out_any_d    = out_any_q;
    rr_ptr_d     = rr_ptr_q;
    if (xfer) begin
      out_valid_d  = 1'b1;
      out_any_d    = hi_found;
      out_idx_d    = hi_found ? win_idx : '0;
      out_onehot_d = hi_found ? oh_full[N-1:0] : '0;
      if (mode_e'(mode) == MODE_RR && hi_found) rr_ptr_d = win_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      out_any_q    <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      out_any_q    <= out_any_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;
  assign out_any    = out_any_q;

`ifdef PRIO_ENCOD_PIPE_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (xfer && hi_found && grant_cnt_q != '1) grant_cnt_d = grant_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) grant_cnt_q <= '0;
    else        grant_cnt_q <= grant_cnt_d;
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_prio_encod_pipe.sv
module tb_prio_encod_pipe;
  import prio_encod_pkg::*;

  localparam int N  = 8;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, mode, out_valid, out_ready, out_any;
  logic [N-1:0]  req, out_onehot;
  logic [IW-1:0] out_idx;
`ifdef PRIO_ENCOD_PIPE_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] grant_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prio_encod_pipe #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .req(req), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_onehot(out_onehot),
`ifdef PRIO_ENCOD_PIPE_GRANT_CNT_EN
    .grant_cnt(grant_cnt),
`endif
    .out_any(out_any)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; req = '0; mode = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_onehot", 32'(out_onehot), 32'd0);
    chk("rst_out_any", 32'(out_any), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Fixed mode, highest set bit of 0010_1100 is 5
    in_valid = 1'b1; mode = 1'b0; req = 8'b0010_1100;
    step();
    chk("fix_valid", 32'(out_valid), 32'd1);
    chk("fix_idx", 32'(out_idx), 32'd5);
    chk("fix_onehot", 32'(out_onehot), 32'h20);
    chk("fix_any", 32'(out_any), 32'd1);
    in_valid = 1'b0;
    step();
    chk("fix_drain_valid", 32'(out_valid), 32'd0);

    // Round robin, req 1000_0001 back to back: 7, 0, 7
    in_valid = 1'b1; mode = 1'b1; req = 8'h81;
    step(); chk("rr_idx_1", 32'(out_idx), 32'd7);
    step(); chk("rr_idx_2", 32'(out_idx), 32'd0);
    chk("rr_onehot_2", 32'(out_onehot), 32'h01);
    step(); chk("rr_idx_3", 32'(out_idx), 32'd7);
    chk("rr_valid_3", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();

    // Zero request: result with out_any=0; rr_ptr (7) untouched
    in_valid = 1'b1; mode = 1'b1; req = 8'h00;
    step();
    chk("zero_valid", 32'(out_valid), 32'd1);
    chk("zero_any", 32'(out_any), 32'd0);
    chk("zero_idx", 32'(out_idx), 32'd0);
    chk("zero_onehot", 32'(out_onehot), 32'd0);
`ifdef PRIO_ENCOD_PIPE_GRANT_CNT_EN
    chk("zero_grant_cnt", 32'(grant_cnt), 32'd4);
`endif
    req = 8'h81;
    step();
    chk("zero_rrptr_kept", 32'(out_idx), 32'd0);

    // Fixed transfer must not move rr_ptr (currently 0)
    mode = 1'b0; req = 8'h0A;
    step(); chk("fix_idx_0a", 32'(out_idx), 32'd3);
    mode = 1'b1;
    step(); chk("rr_after_fix", 32'(out_idx), 32'd3);
    step(); chk("rr_0a_rotate", 32'(out_idx), 32'd1);
    in_valid = 1'b0;
    step();

    // Backpressure
    in_valid = 1'b1; mode = 1'b0; req = 8'h04;
    step();
    chk("bp_first_idx", 32'(out_idx), 32'd2);
    out_ready = 1'b0; req = 8'h40;
    #1;
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    step();
    chk("bp_hold_idx", 32'(out_idx), 32'd2);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_onehot", 32'(out_onehot), 32'h04);
    step();
    chk("bp_hold_idx_2", 32'(out_idx), 32'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", 32'(in_ready), 32'd1);
    step();
    chk("bp_next_idx", 32'(out_idx), 32'd6);
    chk("bp_no_bubble", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_drain_valid", 32'(out_valid), 32'd0);

    // Async reset mid-cycle with a held result; rr_ptr 1 -> winner 4
    in_valid = 1'b1; mode = 1'b1; req = 8'h10;
    step();
    chk("ar_pre_idx", 32'(out_idx), 32'd4);
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", 32'(out_valid), 32'd0);
    #1;
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; mode = 1'b1; req = 8'hFF;
    step();
    chk("ar_first_rr", 32'(out_idx), 32'd7);
    // Single requester wins regardless of rr_ptr position
    req = 8'h80;
    step(); chk("single_rr", 32'(out_idx), 32'd7);
    mode = 1'b0; req = 8'h02;
    step(); chk("single_fix", 32'(out_idx), 32'd1);
    in_valid = 1'b0;
    step();

`ifdef PRIO_ENCOD_PIPE_GRANT_CNT_EN
    in_valid = 1'b1; mode = 1'b0; req = 8'h01;
    for (int i = 0; i < 70000; i++) step();
    in_valid = 1'b0;
    step();
    chk("grant_cnt_sat", 32'(grant_cnt), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_encod_pipe.md
Name: prio_encod_pipe

Overview:
- Parametrised, registered successor of the team's 8-bit priority encoder.
- Accepts an N-bit request vector over a valid/ready handshake and returns the winning index one cycle later through a backpressurable output register.
- Two arbitration modes: fixed (highest set index wins) and round-robin (rotating priority after each grant).
- Sits between request-collection logic and downstream dispatch.

Parameters:
- N, 8, request vector width; legal values ≥ 2.
- IW, $clog2(N), index width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request vector present
- in_ready  output  1  block can accept this cycle
- req  input  N  request bits; bit i = requester i
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled with the transfer
- out_valid  output  1  result register holds a result
- out_ready  input  1  downstream consumes the result
- out_idx  output  IW  winning index
- out_onehot  output  N  one-hot of out_idx; all zero when out_any = 0
- out_any  output  1  req was non-zero at the transfer

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_idx=0, out_onehot=0, out_any=0, rr_ptr=0.
- Handshake and latency:
  - in_ready = !out_valid || out_ready (combinational; one-entry pipeline, full throughput).
  - Input transfer when in_valid && in_ready; result registered on that edge.
  - out_valid=1 the next cycle: latency 1.
  - Output transfer when out_valid && out_ready. If no new input arrives that cycle, out_valid clears.
  - While out_valid && !out_ready, all out_* fields hold stable.
- Fixed mode: winner = highest set index of req, matching the legacy 8-bit encoder for N=8.
- Round-robin mode:
  - Search order is rr_ptr-1, rr_ptr-2, … down to 0, then wraps to N-1 … rr_ptr (mod N). rr_ptr=0 starts the search at N-1.
  - Implementation: masked search over bits below rr_ptr; if none are set, unmasked search over all bits.
  - On each accepted transfer in RR mode with a non-zero req, rr_ptr ← winner index.
  - Result: the last winner has the lowest priority on the next RR transfer.
- rr_ptr is unchanged by fixed-mode transfers and by zero-request transfers.
- Zero request: the transfer still produces a result, with out_any=0, out_idx=0, out_onehot=0.
- Mode switch between transfers takes effect on the next transfer; no flush needed.
- Simultaneous output consume and new input accept in the same cycle: the register reloads, out_valid stays 1, no bubble.
- Reset asserted mid-operation drops any pending result immediately; nothing is replayed after release.
- Single requester: that index wins in both modes.

Optional Feature:
- Macro: PRIO_ENCOD_PIPE_GRANT_CNT_EN.
- Defined:
  - Adds output port grant_cnt, 16 bits.
  - Increments by 1 on every accepted input transfer with non-zero req.
  - Saturates at 16'hFFFF; reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package prio_encod_pkg holds:
  - typedef mode_e (MODE_FIXED=1'b0, MODE_RR=1'b1);
  - constant GRANT_CNT_W=16;
  - function onehot_of(idx).
- One sub-module, prio_find_hi, holds the search logic:
  - purely combinational, parameter N;
  - inputs vec[N-1:0]; outputs idx[IW-1:0] and found.
  - Instantiated twice: masked and unmasked search.
- The top holds the handshake register, rr_ptr and the optional counter.

Test Plan (N=8):
- Fixed mode, req=8'b0010_1100, out_ready=1 → next cycle out_valid=1, out_idx=5, out_onehot=8'b0010_0000, out_any=1.
- RR mode, req held at 8'b1000_0001 for 3 back-to-back transfers from reset → out_idx sequence 7, 0, 7; rr_ptr 7, 0, 7.
- Backpressure: out_ready=0 after the first result (req=8'h04) while in_valid stays high with req=8'h40 → in_ready=0, out_idx holds 2; on out_ready=1 the same cycle accepts req=8'h40, next out_idx=6 with no bubble.
- Zero request, req=8'h00 → out_any=0, out_idx=0, out_onehot=0, rr_ptr unchanged, and grant_cnt unchanged if the macro is enabled.
- Async reset: assert rst_n=0 mid-cycle with out_valid=1 → out_valid drops immediately; after release the first RR transfer with req=8'hFF gives out_idx=7.
- With the macro enabled: 70000 non-zero transfers → grant_cnt=16'hFFFF, saturated.
